// File: rtl/pps_gen.sv
// pps_gen: pulse-per-second transmitter fed by rtclock sec/nsec.
// A registered pulse of programmable width starts each time the local
// time enters a new second; a one-cycle strobe and the seconds value the
// pulse marks come with it. Non-incremental seconds changes (time loads)
// are counted.
// Optional feature macro: PPS_GEN_OFFSET_EN adds the offset_ns port so the
// pulse can be delayed by a phase offset after the second boundary.
module pps_gen #(
  parameter int C_CLK_TO_NS_RATIO = 8,
  parameter int C_WIDTH_BITS      = 24
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [47:0]             sec,
  input  logic [29:0]             nsec,
  input  logic                    enable,
  input  logic [C_WIDTH_BITS-1:0] pulse_width,
`ifdef PPS_GEN_OFFSET_EN
  input  logic [29:0]             offset_ns,
`endif
  output logic                    pps_out,
  output logic                    pps_stb,
  output logic [47:0]             pps_sec,
  output logic [15:0]             jump_cnt
);

  localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;

  // The clock/ns ratio only documents the nsec step; nothing depends on it.
  generate
    if (C_CLK_TO_NS_RATIO <= 0) begin : g_ratio_unused
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARMED, HIGH} state_t;

  state_t                  state_q, state_d;
  logic [47:0]             s1_sec, prev_sec;
  logic [29:0]             s1_nsec, offset_eff;
  logic                    s1_vld, prev_ok;
  logic                    armed_q, armed_d, arm;
  logic [C_WIDTH_BITS-1:0] cnt_q, cnt_d, width_ld;
  logic                    out_d, stb_d, load_sec;
  logic                    tick, jump, phase_ok;

`ifdef PPS_GEN_OFFSET_EN
  assign offset_eff = offset_ns;
`else
  // Without the offset feature the pulse sits right on the second boundary.
  assign offset_eff = '0;
`endif

  // 48-bit modular increment: all-ones -> 0 also counts as a tick.
  assign tick     = prev_ok && (s1_sec == prev_sec + 48'd1);
  assign jump     = prev_ok && (s1_sec != prev_sec) && !tick;
  // An offset of a full second or more can never be reached.
  assign phase_ok = (offset_eff < NS_PER_SEC) && (s1_nsec >= offset_eff);
  assign width_ld = (pulse_width == '0) ? C_WIDTH_BITS'(1) : pulse_width;

  // Input stage S1 plus one-cycle history for tick/jump detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_sec   <= '0;
      s1_nsec  <= '0;
      s1_vld   <= 1'b0;
      prev_sec <= '0;
      prev_ok  <= 1'b0;
    end else begin
      s1_sec   <= sec;
      s1_nsec  <= nsec;
      s1_vld   <= 1'b1;
      prev_sec <= s1_sec;
      prev_ok  <= s1_vld;
    end
  end

  // Pulse owed for the current second: a tick sets it, a jump cancels it.
  // From IDLE only a tick can arm, so re-enabling mid-second waits.
  always_comb begin
    arm = 1'b0;
    if (state_q == IDLE) arm = tick;
    else if (tick)       arm = 1'b1;
    else if (jump)       arm = 1'b0;
    else                 arm = armed_q;
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    out_d    = pps_out;
    stb_d    = 1'b0;
    load_sec = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      armed_d = 1'b0;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else if (arm && phase_ok) begin
      // Trigger; also reloads when already HIGH (pulse wider than a second).
      state_d  = HIGH;
      armed_d  = 1'b0;
      cnt_d    = width_ld;
      out_d    = 1'b1;
      stb_d    = 1'b1;
      load_sec = 1'b1;
    end else begin
      armed_d = arm;
      if (state_q == HIGH) begin
        if (cnt_q <= C_WIDTH_BITS'(1)) begin
          state_d = ARMED;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - C_WIDTH_BITS'(1);
        end
      end else if (arm) begin
        state_d = ARMED;
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      pps_out <= 1'b0;
      pps_stb <= 1'b0;
      pps_sec <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pps_out <= out_d;
      pps_stb <= stb_d;
      if (load_sec) pps_sec <= s1_sec;
    end
  end

  // Saturating time-load counter, independent of enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          jump_cnt <= '0;
    else if (jump && jump_cnt != 16'hFFFF) jump_cnt <= jump_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pps_gen.sv
// tb_pps_gen: directed plus randomized stimulus for pps_gen, checked every
// cycle against a second-level reference model and at key points against
// fixed expectations.
module tb_pps_gen;
  localparam int W = 24;

  logic          clk = 1'b0;
  logic          resetn;
  logic [47:0]   sec;
  logic [29:0]   nsec;
  logic          enable;
  logic [W-1:0]  pulse_width;
`ifdef PPS_GEN_OFFSET_EN
  logic [29:0]   offset_ns;
`endif
  logic          pps_out, pps_stb;
  logic [47:0]   pps_sec;
  logic [15:0]   jump_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [47:0] m_s1, m_prev, m_psec;
  logic [29:0] m_s1_ns, m_off;
  bit          m_s1_v, m_prev_v, m_owed, m_stb;
  int          m_rem, m_jumps;

  pps_gen #(.C_CLK_TO_NS_RATIO(8), .C_WIDTH_BITS(W)) dut (
    .clk(clk), .resetn(resetn), .sec(sec), .nsec(nsec), .enable(enable),
    .pulse_width(pulse_width),
`ifdef PPS_GEN_OFFSET_EN
    .offset_ns(offset_ns),
`endif
    .pps_out(pps_out), .pps_stb(pps_stb), .pps_sec(pps_sec), .jump_cnt(jump_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_prev = '0; m_psec = '0; m_s1_ns = '0;
    m_s1_v = 0; m_prev_v = 0; m_owed = 0; m_stb = 0;
    m_rem = 0; m_jumps = 0;
  endtask

  // One clock of the reference: sec/nsec seen one cycle late, enable,
  // width and offset seen directly.
  task automatic model_clock();
    bit tick, jump;
    if (m_prev == 48'hFFFF_FFFF_FFFF) tick = m_prev_v && m_s1_v && (m_s1 == 48'd0);
    else                              tick = m_prev_v && m_s1_v && (m_s1 == m_prev + 48'd1);
    jump = m_prev_v && (m_s1 != m_prev) && !tick;
    if (jump && m_jumps < 65535) m_jumps++;
    m_stb = 0;
    if (!enable) begin
      m_owed = 0;
      m_rem  = 0;
    end else begin
      if (tick)      m_owed = 1;
      else if (jump) m_owed = 0;
      if (m_owed && m_off < 30'd1_000_000_000 && m_s1_ns >= m_off) begin
        m_rem  = (pulse_width == 0) ? 1 : int'(pulse_width);
        m_psec = m_s1;
        m_stb  = 1;
        m_owed = 0;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
    m_prev = m_s1; m_prev_v = m_s1_v;
    m_s1 = sec; m_s1_ns = nsec; m_s1_v = 1;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    @(negedge clk);
    chk("m_out",  64'(pps_out),  64'(m_rem > 0));
    chk("m_stb",  64'(pps_stb),  64'(m_stb));
    chk("m_sec",  64'(pps_sec),  64'(m_psec));
    chk("m_jump", 64'(jump_cnt), 64'(m_jumps));
  endtask

  task automatic set_off(input logic [29:0] o);
    m_off = o;
`ifdef PPS_GEN_OFFSET_EN
    offset_ns = o;
`endif
  endtask

  initial begin
    int hc, hi, strobes;
    logic [15:0] outs;
    resetn = 0; enable = 0; pulse_width = 24'd10; sec = '0; nsec = '0;
    set_off(30'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out",  64'(pps_out), 64'd0);
    chk("rst_stb",  64'(pps_stb), 64'd0);
    chk("rst_sec",  64'(pps_sec), 64'd0);
    chk("rst_jump", 64'(jump_cnt), 64'd0);
    resetn = 1;

    // First pulse: width 10, sec 5 -> 6
    enable = 1; sec = 48'd5; nsec = 30'd999_999_992;
    repeat (3) step();
    sec = 48'd6; nsec = 30'd0;
    step(); chk("p6_lat1", 64'(pps_out), 64'd0);
    step(); chk("p6_out", 64'(pps_out), 64'd1);
    chk("p6_stb", 64'(pps_stb), 64'd1);
    chk("p6_sec", 64'(pps_sec), 64'd6);
    hc = 1;
    repeat (11) begin nsec += 30'd8; step(); hc += int'(pps_out); end
    chk("p6_width", 64'(hc), 64'd10);

    // Time load 6 -> 10: no pulse, one jump; 10 -> 11 pulses
    sec = 48'd10; nsec = 30'd0; hi = 0;
    repeat (4) begin step(); hi += int'(pps_out); end
    chk("load_nopulse", 64'(hi), 64'd0);
    chk("load_jump", 64'(jump_cnt), 64'd1);
    sec = 48'd11;
    step(); step();
    chk("p11_out", 64'(pps_out), 64'd1);
    chk("p11_sec", 64'(pps_sec), 64'd11);
    repeat (12) step();

    // Width 0 and 48-bit wrap
    pulse_width = '0; sec = 48'hFFFF_FFFF_FFFF;
    repeat (3) step();
    sec = 48'd0;
    step(); step();
    chk("wrap_out", 64'(pps_out), 64'd1);
    chk("wrap_sec", 64'(pps_sec), 64'd0);
    step();
    chk("w0_fall", 64'(pps_out), 64'd0);

    // Enable dropped mid-pulse, re-enabled mid-second
    pulse_width = 24'd10; sec = 48'd1;
    repeat (4) step();
    chk("en_mid_high", 64'(pps_out), 64'd1);
    enable = 0; step();
    chk("en_drop", 64'(pps_out), 64'd0);
    repeat (2) step();
    nsec = 30'd500_000_000; enable = 1; hi = 0;
    repeat (6) begin step(); hi += int'(pps_out); end
    chk("reen_nopulse", 64'(hi), 64'd0);
    sec = 48'd2; nsec = 30'd0;
    step(); step();
    chk("reen_next", 64'(pps_out), 64'd1);
    chk("reen_sec", 64'(pps_sec), 64'd2);
    repeat (12) step();

    // Width 5, ticks three cycles apart: one merged high period
    pulse_width = 24'd5; sec = 48'd3; strobes = 0; outs = '0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) sec = 48'd4;
      step();
      outs[i] = pps_out;
      strobes += int'(pps_stb);
    end
    chk("retrig_shape", 64'(outs), 64'h03FC);
    chk("retrig_strobes", 64'(strobes), 64'd2);

    // Jump coinciding with enable rise
    enable = 0; repeat (2) step();
    sec = 48'd100; enable = 1; hi = 0;
    repeat (3) begin step(); hi += int'(pps_out); end
    chk("jen_jump", 64'(jump_cnt), 64'd3);
    chk("jen_nopulse", 64'(hi), 64'd0);
    pulse_width = 24'd10; sec = 48'd101;
    step(); step();
    chk("jen_next_sec", 64'(pps_sec), 64'd101);

    // Asynchronous reset mid-pulse
    step();
    #2 resetn = 0;
    #1 chk("arst_out", 64'(pps_out), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    sec = 48'd102; nsec = 30'd0;
    repeat (3) step();
    chk("arst_nojump", 64'(jump_cnt), 64'd0);
    sec = 48'd103;
    repeat (14) step();

`ifdef PPS_GEN_OFFSET_EN
    // Phase offset 400 ns
    set_off(30'd400); sec = 48'd104; nsec = 30'd0; hi = 0;
    step();
    for (int ns = 8; ns <= 392; ns += 8) begin
      nsec = 30'(ns); step(); hi += int'(pps_out);
    end
    chk("off_early", 64'(hi), 64'd0);
    nsec = 30'd400;
    step(); chk("off_lat", 64'(pps_out), 64'd0);
    step(); chk("off_out", 64'(pps_out), 64'd1);
    chk("off_sec", 64'(pps_sec), 64'd104);
    repeat (12) begin nsec += 30'd8; step(); end
    set_off(30'd1_000_000_000); hi = 0;
    repeat (3) begin
      sec = sec + 48'd1; nsec = 30'd0;
      repeat (10) begin step(); hi += int'(pps_out); nsec += 30'd8; end
    end
    chk("off_never", 64'(hi), 64'd0);
    set_off(30'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12)      begin sec = sec + 48'd1; nsec = 30'd0; end
      else if (r < 15) sec = sec + 48'($urandom_range(2, 50));
      else if (r < 16) sec = 48'hFFFF_FFFF_FFFE;
      else if (nsec < 30'd999_999_992) nsec += 30'd8;
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) pulse_width = W'($urandom_range(0, 7));
`ifdef PPS_GEN_OFFSET_EN
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: set_off(30'd0);
          1: set_off(30'd16);
          2: set_off(30'd40);
          default: set_off(30'd1_000_000_000);
        endcase
      end
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
